wb_retire: RTL and testbench

WB_RETIRE -- requirements
Module: wb_retire

---
 rtl/wb_retire_pkg.sv | 40 ++++
 rtl/wb_retire_dest_decode.sv | 56 +++++
 rtl/wb_retire.sv | 93 +++++++++
 tb/tb_wb_retire.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_retire_pkg.sv
// Shared opcode/funct constants and retire-entry types for the writeback stage
// and the decode-stage hazard logic.
package wb_retire_pkg;

    localparam int REGFILE_SIZE = 32;

    localparam logic [5:0] R_FORM = 6'h00;
    localparam logic [5:0] BGEZ   = 6'h01;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] BLEZ   = 6'h06;
    localparam logic [5:0] BGTZ   = 6'h07;
    localparam logic [5:0] SW     = 6'h2B;

    localparam logic [5:0] JR     = 6'h08;
    localparam logic [5:0] MTHI   = 6'h11;
    localparam logic [5:0] MTLO   = 6'h13;
    localparam logic [5:0] MULT   = 6'h18;
    localparam logic [5:0] MULTU  = 6'h19;
    localparam logic [5:0] DIV    = 6'h1A;
    localparam logic [5:0] DIVU   = 6'h1B;

    typedef enum logic [1:0] {
        HILO_NONE = 2'd0,
        HILO_BOTH = 2'd1,
        HILO_HI   = 2'd2,
        HILO_LO   = 2'd3
    } hilo_op_t;

    typedef struct packed {
        logic        gpr_we;
        logic [4:0]  dest;
        hilo_op_t    hilo_op;
        logic [31:0] data;
        logic [31:0] hi;
    } ret_entry_t;

endpackage

// File: rtl/wb_retire_dest_decode.sv
// Combinational destination decode: which GPR (if any) and which of HI/LO an
// instruction writes when it retires.
module wb_dest_decode
    import wb_retire_pkg::*;
#(
    parameter int REGFILE_SIZE = 32
) (
    input  logic [31:0] Ins,
    output logic        gpr_we,
    output logic [4:0]  dest,
    output hilo_op_t    hilo_op
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       we_raw;
    logic       unused_fields;

    assign opcode        = Ins[31:26];
    assign funct         = Ins[5:0];
    assign unused_fields = ^{Ins[25:21], Ins[10:6]};

    always_comb begin
        we_raw  = 1'b1;
        dest    = Ins[20:16];
        hilo_op = HILO_NONE;
        case (opcode)
            R_FORM: begin
                dest = Ins[15:11];
                case (funct)
                    MULT, MULTU, DIV, DIVU: begin
                        we_raw  = 1'b0;
                        hilo_op = HILO_BOTH;
                    end
                    MTHI: begin
                        we_raw  = 1'b0;
                        hilo_op = HILO_HI;
                    end
                    MTLO: begin
                        we_raw  = 1'b0;
                        hilo_op = HILO_LO;
                    end
                    JR:      we_raw = 1'b0;
                    default: we_raw = 1'b1;
                endcase
            end
            SW, BEQ, BNE, BGEZ, BGTZ, BLEZ, J: we_raw = 1'b0;
            JAL:     dest = 5'(REGFILE_SIZE - 1);
            default: dest = Ins[20:16];
        endcase
    end

    // $0 is hardwired; suppress the write here so every consumer sees it.
    assign gpr_we = we_raw && (dest != 5'd0);

endmodule

// File: rtl/wb_retire.sv
// Writeback retire buffer: small FIFO of retiring instructions draining into
// the register-file write port and the architectural HI/LO registers.
module wb_retire
    import wb_retire_pkg::*;
#(
    parameter int REGFILE_SIZE = 32,
    parameter int DEPTH        = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] ResultHi,
    input  logic [31:0] Link,
    input  logic        port_busy,
    output logic        Wen,
    output logic [4:0]  Waddr,
    output logic [31:0] Wdata,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic [2:0]  occ
);

    ret_entry_t  ent_q [DEPTH];
    ret_entry_t  new_ent;
    ret_entry_t  head;
    logic [1:0]  wptr, rptr;
    logic        push, pop;
    logic        dec_we;
    logic [4:0]  dec_dest;
    hilo_op_t    dec_hilo;

    wb_dest_decode #(.REGFILE_SIZE(REGFILE_SIZE)) u_dec (
        .Ins     (Ins),
        .gpr_we  (dec_we),
        .dest    (dec_dest),
        .hilo_op (dec_hilo)
    );

    always_comb begin
        new_ent         = '0;
        new_ent.gpr_we  = dec_we;
        new_ent.dest    = dec_dest;
        new_ent.hilo_op = dec_hilo;
        new_ent.data    = (Ins[31:26] == JAL) ? Link : Result;
        new_ent.hi      = ResultHi;
    end

    assign in_ready = RST && (occ < 3'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (occ != 3'd0) && !port_busy;
    assign head     = ent_q[rptr];

    always_ff @(posedge CLK) begin
        if (push) ent_q[wptr] <= new_ent;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            occ   <= '0;
            Wen   <= 1'b0;
            Waddr <= '0;
            Wdata <= '0;
            Hi    <= '0;
            Lo    <= '0;
        end else begin
            if (push) wptr <= (wptr == 2'(DEPTH - 1)) ? 2'd0 : wptr + 2'd1;
            if (pop)  rptr <= (rptr == 2'(DEPTH - 1)) ? 2'd0 : rptr + 2'd1;
            occ <= occ + 3'(push) - 3'(pop);
            Wen <= pop && head.gpr_we;
            if (pop && head.gpr_we) begin
                Waddr <= head.dest;
                Wdata <= head.data;
            end
            if (pop) begin
                case (head.hilo_op)
                    HILO_BOTH: begin
                        Lo <= head.data;
                        Hi <= head.hi;
                    end
                    HILO_HI: Hi <= head.data;
                    HILO_LO: Lo <= head.data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_retire.sv
// Directed bench for wb_retire (DEPTH=2): timing, decode, HI/LO, backpressure,
// pointer wrap and mid-operation reset.
module tb_wb_retire;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Ins, Result, ResultHi, Link;
    logic        port_busy;
    logic        Wen;
    logic [4:0]  Waddr;
    logic [31:0] Wdata, Hi, Lo;
    logic [2:0]  occ;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [4:0]  got_a[$];
    logic [31:0] got_d[$];

    wb_retire #(.REGFILE_SIZE(32), .DEPTH(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ins       (Ins),
        .Result    (Result),
        .ResultHi  (ResultHi),
        .Link      (Link),
        .port_busy (port_busy),
        .Wen       (Wen),
        .Waddr     (Waddr),
        .Wdata     (Wdata),
        .Hi        (Hi),
        .Lo        (Lo),
        .occ       (occ)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (Wen === 1'b1) begin
            got_a.push_back(Waddr);
            got_d.push_back(Wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rt);
        return {6'h08, 5'd0, rt, 16'h0000};
    endfunction

    function automatic logic [31:0] rform(input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    task automatic push(input logic [31:0] ins, input logic [31:0] res,
                        input logic [31:0] rhi, input logic [31:0] lnk);
        int unsigned waited = 0;
        Ins = ins; Result = res; ResultHi = rhi; Link = lnk;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned waited = 0;
        while (occ != 3'd0 && waited < 50) begin
            tick();
            waited++;
        end
        check("drain_occ", 32'(occ), 32'd0);
        tick();
        tick();
    endtask

    logic [4:0]  exp_a[8];
    logic [31:0] exp_d[8];

    initial begin
        int unsigned n0;
        int unsigned idx;
        int unsigned cyc;

        RST = 1'b0; in_valid = 1'b0; port_busy = 1'b0;
        Ins = '0; Result = '0; ResultHi = '0; Link = '0;

        // reset state
        tick(); tick();
        check("rst_occ",   32'(occ),      32'd0);
        check("rst_wen",   32'(Wen),      32'd0);
        check("rst_waddr", 32'(Waddr),    32'd0);
        check("rst_wdata", Wdata,         32'd0);
        check("rst_hi",    Hi,            32'd0);
        check("rst_lo",    Lo,            32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        RST = 1'b1;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // ADDI $8 = 5: Wen two cycles after the capture cycle
        Ins = addi(5'd8); Result = 32'h5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("addi_occ1",   32'(occ), 32'd1);
        check("addi_wen_c1", 32'(Wen), 32'd0);
        tick();
        check("addi_wen",   32'(Wen),   32'd1);
        check("addi_waddr", 32'(Waddr), 32'd8);
        check("addi_wdata", Wdata,      32'h5);
        tick();
        check("addi_wen_1cyc", 32'(Wen),   32'd0);
        check("addi_hold",     32'(Waddr), 32'd8);

        // JAL writes link register with Link
        n0 = got_a.size();
        push({6'h03, 26'h0}, 32'hDEAD, 32'h0, 32'h40);
        drain();
        check("jal_count", got_a.size(), n0 + 1);
        if (got_a.size() == n0 + 1) begin
            check("jal_waddr", 32'(got_a[n0]), 32'd31);
            check("jal_wdata", got_d[n0],      32'h40);
        end

        // SW, BEQ, ADD to $0 never write
        n0 = got_a.size();
        push({6'h2B, 5'd1, 5'd3, 16'h4}, 32'h11, 32'h0, 32'h0);
        push({6'h04, 5'd1, 5'd3, 16'h4}, 32'h22, 32'h0, 32'h0);
        push(rform(5'd0, 6'h20),         32'h33, 32'h0, 32'h0);
        drain();
        check("nowrite_count", got_a.size(), n0);

        // MULT then MTHI
        n0 = got_a.size();
        push(rform(5'd0, 6'h18), 32'h1, 32'h2, 32'h0);
        tick();
        check("mult_lo", Lo, 32'h1);
        check("mult_hi", Hi, 32'h2);
        push(rform(5'd0, 6'h11), 32'h7, 32'h9, 32'h0);
        tick();
        check("mthi_hi", Hi, 32'h7);
        check("mthi_lo", Lo, 32'h1);
        drain();
        check("hilo_nowen", got_a.size(), n0);

        // backpressure: third entry held upstream while full
        n0 = got_a.size();
        port_busy = 1'b1;
        push(addi(5'd9),  32'h11, 32'h0, 32'h0);
        push(addi(5'd10), 32'h22, 32'h0, 32'h0);
        check("full_occ",   32'(occ),      32'd2);
        check("full_ready", 32'(in_ready), 32'd0);
        Ins = addi(5'd11); Result = 32'h33; in_valid = 1'b1;
        tick(); tick();
        check("full_hold_occ", 32'(occ), 32'd2);
        port_busy = 1'b0;
        push(addi(5'd11), 32'h33, 32'h0, 32'h0);
        drain();
        check("bp_count", got_a.size(), n0 + 3);
        if (got_a.size() == n0 + 3) begin
            check("bp_a0", 32'(got_a[n0]),     32'd9);
            check("bp_d0", got_d[n0],          32'h11);
            check("bp_a1", 32'(got_a[n0 + 1]), 32'd10);
            check("bp_d1", got_d[n0 + 1],      32'h22);
            check("bp_a2", 32'(got_a[n0 + 2]), 32'd11);
            check("bp_d2", got_d[n0 + 2],      32'h33);
        end

        // 8 writes, port_busy toggling every cycle
        n0 = got_a.size();
        for (int i = 0; i < 8; i++) begin
            exp_a[i] = 5'(i + 12);
            exp_d[i] = 32'h100 + 32'(i * 3);
        end
        idx = 0;
        cyc = 0;
        while ((idx < 8 || occ != 3'd0) && cyc < 100) begin
            port_busy = cyc[0];
            if (idx < 8) begin
                Ins = addi(exp_a[idx]); Result = exp_d[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; port_busy = 1'b0;
        tick(); tick();
        check("b2b_count", got_a.size(), n0 + 8);
        if (got_a.size() == n0 + 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("b2b_a%0d", i), 32'(got_a[n0 + i]), 32'(exp_a[i]));
                check($sformatf("b2b_d%0d", i), got_d[n0 + i],      exp_d[i]);
            end
        end

        // reset with two buffered entries
        n0 = got_a.size();
        port_busy = 1'b1;
        push(addi(5'd20), 32'hAA, 32'h0, 32'h0);
        push(rform(5'd0, 6'h18), 32'h55, 32'h66, 32'h0);
        check("prerst_occ", 32'(occ), 32'd2);
        RST = 1'b0;
        tick();
        check("midrst_occ", 32'(occ), 32'd0);
        check("midrst_wen", 32'(Wen), 32'd0);
        check("midrst_hi",  Hi,       32'd0);
        check("midrst_lo",  Lo,       32'd0);
        RST = 1'b1; port_busy = 1'b0;
        tick(); tick(); tick();
        check("midrst_nowen", got_a.size(), n0);
        check("midrst_lo_stay", Lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
